// File: rtl/apb_sched_pkg.sv
// Shared types and constants for the APB request scheduler.
package apb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int STRB_W      = 4;
    localparam int TMO_DEFAULT = 64;
    localparam int TMO_CW      = $clog2(TMO_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // scan last+1, last+2, ... with wrap; the first hit wins
    always_comb begin
        int j;
        logic [IW-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(last) + k) % N;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/apb_req_scheduler.sv
// Shares one APB master between NREQ requesters: picks an owner round-robin,
// latches its command, drives the master, and returns one response pulse.
module apb_req_scheduler
    import apb_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 33,
    parameter int DW   = 32,
    parameter int TMO  = 64
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    input  logic [NREQ*STRB_W-1:0]   req_strb,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_tmo,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     transfer,
    output logic                     READ_WRITE,
    output logic [AW-1:0]            get_w_paddr,
    output logic [AW-1:0]            get_r_paddr,
    output logic [DW-1:0]            get_w_data_in,
    output logic [STRB_W-1:0]        PSTRB,
    input  logic                     PENABLE,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    input  logic [DW-1:0]            send_r_out
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO);

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   cur;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            tmo_q;

    logic [NREQ-1:0] pk_gnt;
    logic [IW-1:0]   pk_idx;
    logic            pk_any;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req  (req_valid),
        .last (last),
        .gnt  (pk_gnt),
        .idx  (pk_idx),
        .any  (pk_any)
    );

    logic done;
    assign done = (PENABLE && PREADY) || PSLVERR;

    // scheduler FSM; every output is a register so the master sees clean levels
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= IDLE;
            last          <= IW'(NREQ - 1);
            cur           <= '0;
            cnt           <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_tmo       <= 1'b0;
            grant         <= '0;
            busy          <= 1'b0;
            transfer      <= 1'b0;
            READ_WRITE    <= 1'b0;
            get_w_paddr   <= '0;
            get_r_paddr   <= '0;
            get_w_data_in <= '0;
            PSTRB         <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pk_any) begin
                        grant         <= pk_gnt;
                        cur           <= pk_idx;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        transfer      <= 1'b1;
                        READ_WRITE    <= ~req_write[pk_idx];
                        get_w_paddr   <= req_addr[int'(pk_idx)*AW +: AW];
                        get_r_paddr   <= req_addr[int'(pk_idx)*AW +: AW];
                        get_w_data_in <= req_write[pk_idx] ? req_wdata[int'(pk_idx)*DW +: DW] : '0;
                        PSTRB         <= req_write[pk_idx] ? req_strb[int'(pk_idx)*STRB_W +: STRB_W] : '0;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    // a real completion beats a timeout landing on the same cycle
                    if (done) begin
                        transfer <= 1'b0;
                        err_q    <= PSLVERR;
                        tmo_q    <= 1'b0;
                        rdata_q  <= (READ_WRITE && !PSLVERR) ? send_r_out : '0;
                        state    <= RESP;
                    end else if (cnt == CW'(TMO - 1)) begin
                        transfer <= 1'b0;
                        err_q    <= 1'b1;
                        tmo_q    <= 1'b1;
                        rdata_q  <= '0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= grant;
                    rsp_rdata <= rdata_q;
                    rsp_err   <= err_q;
                    rsp_tmo   <= tmo_q;
                    last      <= cur;
                    grant     <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Bench for apb_req_scheduler: APB master/slave model plus a scoreboard that
// predicts grant order, command outputs, latency and response from the rules.
module tb_apb_req_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 33;
    localparam int DW   = 32;
    localparam int TMO  = 8;

    logic                 PCLK = 1'b0;
    logic                 PRESET;
    logic [NREQ-1:0]      req_valid, req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_strb;
    logic [NREQ-1:0]      rsp_valid, grant;
    logic [DW-1:0]        rsp_rdata, get_w_data_in, send_r_out;
    logic                 rsp_err, rsp_tmo, busy, transfer, READ_WRITE;
    logic [AW-1:0]        get_w_paddr, get_r_paddr;
    logic [3:0]           PSTRB;
    logic                 PENABLE, PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_req_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .grant(grant), .busy(busy), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .get_w_paddr(get_w_paddr), .get_r_paddr(get_r_paddr),
        .get_w_data_in(get_w_data_in), .PSTRB(PSTRB),
        .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .send_r_out(send_r_out)
    );

    // master + slave model: IDLE -> SETUP -> ACCESS, slave inserts sl_waits
    int          mst, wcnt, sl_waits;
    bit          sl_err, sl_hang;
    logic [DW-1:0] sl_rdata;

    always @(posedge PCLK) begin
        if (PRESET) begin
            mst  <= 0;
            wcnt <= 0;
        end else begin
            case (mst)
                0: if (transfer) mst <= 1;
                1: begin mst <= 2; wcnt <= 0; end
                default: begin
                    if (PREADY || !transfer) mst <= 0;
                    else wcnt <= wcnt + 1;
                end
            endcase
        end
    end
    assign PENABLE    = (mst == 2);
    assign PREADY     = PENABLE && !sl_hang && (wcnt == sl_waits);
    assign PSLVERR    = PREADY && sl_err;
    assign send_r_out = sl_rdata;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard state
    logic            w_m [NREQ];
    logic [AW-1:0]   a_m [NREQ];
    logic [DW-1:0]   d_m [NREQ];
    logic [3:0]      s_m [NREQ];
    int              last_m, cur, cyc, xhi;
    bit              active, rand_slave, rehold, rand_new, drop_on_grant;
    logic [DW-1:0]   hold_m;
    logic [NREQ-1:0] prev_grant, req_edge;
    int              served[$];

    // winner = pending requester at the smallest cyclic distance after last
    function automatic int pick(logic [NREQ-1:0] r, int lst);
        int best = -1;
        int bd   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            int d = (i - lst - 1 + 2 * NREQ) % NREQ;
            if (r[i] && d < bd) begin bd = d; best = i; end
        end
        return best;
    endfunction

    task automatic set_req(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] s);
        w_m[i] = w; a_m[i] = a; d_m[i] = d; s_m[i] = s;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_strb[i*4 +: 4]     = s;
        req_valid[i]           = 1'b1;
    endtask

    task automatic rand_req(int i);
        set_req(i, 1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 32'($urandom)},
                32'($urandom), 4'($urandom));
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_ctl"}, {grant, busy, transfer, rsp_valid, rsp_err, rsp_tmo, READ_WRITE, PSTRB}, 64'h0);
        chk({tag, "_waddr"}, get_w_paddr, 64'h0);
        chk({tag, "_raddr"}, get_r_paddr, 64'h0);
        chk({tag, "_wdata"}, get_w_data_in, 64'h0);
        chk({tag, "_rdata"}, rsp_rdata, 64'h0);
    endtask

    // one cycle: sample at negedge, score, then drive requesters for the next edge
    task automatic step();
        logic [NREQ-1:0] oh;
        int e, xc;
        bit to, er;
        logic [DW-1:0] rd;
        req_edge = req_valid;
        @(negedge PCLK);
        if (grant != '0 && prev_grant == '0) begin
            e = pick(req_edge, last_m);
            if (e < 0) begin
                chk("grant_noreq", grant, 0);
            end else begin
                oh = '0; oh[e] = 1'b1;
                chk("grant", grant, oh);
                cur = e; cyc = 0; xhi = 0; active = 1;
                chk("busy_on", busy, 1);
                chk("rw", READ_WRITE, !w_m[cur]);
                chk("waddr", get_w_paddr, a_m[cur]);
                chk("raddr", get_r_paddr, a_m[cur]);
                chk("wdata", get_w_data_in, w_m[cur] ? d_m[cur] : '0);
                chk("strb", PSTRB, w_m[cur] ? s_m[cur] : 4'h0);
                if (rand_slave) begin
                    sl_waits = $urandom_range(0, TMO - 1);
                    sl_err   = ($urandom_range(0, 3) == 0);
                    sl_rdata = $urandom;
                end
                if (drop_on_grant) req_valid[cur] = 1'b0;
            end
        end
        if (active) begin
            cyc++;
            to = sl_hang || (3 + sl_waits > TMO);
            xc = to ? TMO : 3 + sl_waits;
            if (transfer) begin
                xhi++;
                chk("cmd_hold", {READ_WRITE, get_w_paddr}, {!w_m[cur], a_m[cur]});
            end
        end
        if (active && rsp_valid != '0) begin
            er = to || sl_err;
            rd = (!er && !w_m[cur]) ? sl_rdata : '0;
            oh = '0; oh[cur] = 1'b1;
            chk("rsp_valid", rsp_valid, oh);
            chk("rsp_err", rsp_err, er);
            chk("rsp_tmo", rsp_tmo, to);
            chk("rsp_rdata", rsp_rdata, rd);
            chk("latency", cyc, xc + 2);
            chk("xfer_cycles", xhi, xc);
            chk("xfer_low_at_rsp", transfer, 0);
            chk("busy_off", busy, 0);
            hold_m = rd;
            last_m = cur;
            active = 0;
            served.push_back(cur);
            req_valid[cur] = 1'b0;
            if (rehold) rand_req(cur);
        end else begin
            chk("rsp_quiet", {rsp_valid, rsp_rdata}, {{NREQ{1'b0}}, hold_m});
            if (active && cyc > TMO + 4) begin
                chk("rsp_late", cyc, xc + 2);
                active = 0;
            end
        end
        if (rand_new)
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) rand_req(i);
        prev_grant = grant;
    endtask

    task automatic run_served(int n, output int steps);
        int tgt = served.size() + n;
        steps = 0;
        while (served.size() < tgt && steps < n * (TMO + 10) + 20) begin
            step();
            steps++;
        end
        chk("served_count", served.size(), tgt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, first, base;
        PRESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        sl_waits = 0; sl_err = 0; sl_hang = 0; sl_rdata = '0;
        rand_slave = 0; rehold = 0; rand_new = 0; drop_on_grant = 0;
        last_m = NREQ - 1; hold_m = '0; active = 0; prev_grant = '0;
        cur = 0; cyc = 0; xhi = 0;
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESET = 1'b0;

        // single write from requester 0, zero wait states
        set_req(0, 1'b1, 33'h0_0000_0010, 32'hA5A5_0F0F, 4'hF);
        run_served(1, st);
        chk("t1_latency", st, 5);
        chk("t1_err", rsp_err, 0);

        // read from requester 1 with two wait states
        sl_waits = 2; sl_rdata = 32'hDEAD_BEEF;
        set_req(1, 1'b0, 33'h1_0000_0004, 32'($urandom), 4'($urandom));
        run_served(1, st);
        chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // all four requesters held: strict rotation
        sl_waits = 0;
        for (int i = 0; i < NREQ; i++) rand_req(i);
        rehold = 1;
        first = (last_m + 1) % NREQ;
        base = served.size();
        run_served(5, st);
        rehold = 0;
        for (int k = 0; k < 5; k++) chk("rr_order", served[base + k], (first + k) % NREQ);
        run_served($countones(req_valid), st);

        // slave never ready: forced timeout
        sl_hang = 1;
        set_req(3, 1'b0, 33'h0_0000_0100, 32'h0, 4'h0);
        run_served(1, st);
        chk("t4_tmo", {rsp_err, rsp_tmo}, 2'b11);
        sl_hang = 0;
        // completion on the very last allowed cycle wins over the timeout
        sl_waits = TMO - 3; sl_rdata = 32'h1234_5678;
        set_req(3, 1'b0, 33'h0_0000_0104, 32'h0, 4'h0);
        run_served(1, st);
        chk("t4_edge_tmo", {rsp_err, rsp_tmo}, 2'b00);
        chk("t4_edge_rdata", rsp_rdata, 32'h1234_5678);
        // one cycle later is a timeout
        sl_waits = TMO - 2;
        set_req(3, 1'b0, 33'h0_0000_0108, 32'h0, 4'h0);
        run_served(1, st);
        chk("t4_late_tmo", {rsp_err, rsp_tmo}, 2'b11);

        // slave error on requester 2, then a normal read with req dropped mid-flight
        sl_waits = 1; sl_err = 1; sl_rdata = 32'hCAFE_F00D;
        set_req(2, 1'b0, 33'h1_0000_0020, 32'h0, 4'h0);
        run_served(1, st);
        chk("t5_err", {rsp_err, rsp_tmo}, 2'b10);
        chk("t5_rdata", rsp_rdata, 0);
        sl_err = 0; drop_on_grant = 1;
        set_req(2, 1'b0, 33'h1_0000_0024, 32'h0, 4'h0);
        run_served(1, st);
        drop_on_grant = 0;
        chk("t5_next_rdata", rsp_rdata, 32'hCAFE_F00D);

        // reset in the middle of a transfer
        sl_waits = 0;
        set_req(1, 1'b1, 33'h0_0000_0040, 32'h5555_AAAA, 4'h3);
        run_served(1, st);
        sl_waits = 3;
        set_req(1, 1'b0, 33'h0_0000_0044, 32'h0, 4'h0);
        st = 0;
        while (!(active && transfer) && st < 10) begin step(); st++; end
        chk("t6_in_xfer", transfer, 1);
        PRESET = 1'b1;
        req_valid = '0;
        @(negedge PCLK);
        check_all_zero("mid_reset");
        active = 0; last_m = NREQ - 1; hold_m = '0; prev_grant = grant;
        PRESET = 1'b0;
        sl_waits = 0;
        set_req(0, 1'b1, 33'h0_0000_0080, 32'h0F0F_0F0F, 4'hF);
        set_req(2, 1'b0, 33'h1_0000_0084, 32'h0, 4'h0);
        base = served.size();
        run_served(2, st);
        chk("t6_first_after_reset", served[base], 0);

        // randomized traffic with random slave timing and errors
        rand_slave = 1; rand_new = 1;
        run_served(40, st);
        rand_new = 0;
        if ($countones(req_valid) > 0) run_served($countones(req_valid), st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
